// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional one-entry skid buffer; bubbles carry zero payload and write enables.
// Build option: define PIPE_SKID_EN for the skid/FULL variant with registered in_ready; otherwise legacy stall.
module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int WE_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [WE_W-1:0]   in_we,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [WE_W-1:0]   out_we,
   input  logic              out_ready,
   output logic [1:0]        occupancy
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;

   // Handshake: an input beat moves when in_valid & in_ready at a rising edge;
   // an output beat moves when out_valid & out_ready at a rising edge.
   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [WE_W-1:0]   main_we_q, main_we_d;
   logic              accept, transfer;

   // The state encoding equals the held count, so occupancy doubles as the FSM debug view.
   assign occupancy = state_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_data_q;
   assign out_we    = main_we_q;
   assign transfer  = out_valid & out_ready;
   assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
   localparam logic [1:0] ST_FULL = 2'd2;

   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [WE_W-1:0]   skid_we_q, skid_we_d;
   logic              in_ready_q;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_we_d   = main_we_q;
      skid_data_d = skid_data_q;
      skid_we_d   = skid_we_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_data_d = in_data;
               main_we_d   = in_we;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && transfer) begin
               main_data_d = in_data;
               main_we_d   = in_we;
            end else if (accept) begin
               skid_data_d = in_data;
               skid_we_d   = in_we;
               state_d     = ST_FULL;
            end else if (transfer) begin
               main_data_d = '0;
               main_we_d   = '0;
               state_d     = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // Skid always drains into main, so the older entry leaves first.
            if (transfer) begin
               main_data_d = skid_data_q;
               main_we_d   = skid_we_q;
               skid_data_d = '0;
               skid_we_d   = '0;
               state_d     = ST_ONE;
            end
         end
         default: begin
            main_data_d = '0;
            main_we_d   = '0;
            skid_data_d = '0;
            skid_we_d   = '0;
            state_d     = ST_EMPTY;
         end
      endcase
      if (flush) begin
         main_data_d = '0;
         main_we_d   = '0;
         skid_data_d = '0;
         skid_we_d   = '0;
         state_d     = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_we_q   <= '0;
         skid_data_q <= '0;
         skid_we_q   <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_we_q   <= main_we_d;
         skid_data_q <= skid_data_d;
         skid_we_q   <= skid_we_d;
         in_ready_q  <= (state_d != ST_FULL);
      end
   end

`else
   // Legacy stall: upstream may only advance when main is free or leaving this cycle.
   assign in_ready = out_ready | ~out_valid;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_we_d   = main_we_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_data_d = in_data;
               main_we_d   = in_we;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept) begin
               main_data_d = in_data;
               main_we_d   = in_we;
            end else if (transfer) begin
               main_data_d = '0;
               main_we_d   = '0;
               state_d     = ST_EMPTY;
            end
         end
         default: begin
            main_data_d = '0;
            main_we_d   = '0;
            state_d     = ST_EMPTY;
         end
      endcase
      if (flush) begin
         main_data_d = '0;
         main_we_d   = '0;
         state_d     = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_we_q   <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_we_q   <= main_we_d;
      end
   end
`endif

endmodule
